// File: rtl/sobel_window_buffer.sv
// rtl/sobel_window_buffer.sv - two-line buffer and 3x3 window generator for the Sobel stage
module sobel_window_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int COL_BITS    = $clog2(IMG_WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     start_i,
    input  logic                     finish_i,
    input  logic                     px_valid_i,
    input  logic [PIXEL_WIDTH-1:0]   px_gray_i,
    output logic                     busy_o,
    output logic                     window_valid_o,
    output logic [9*PIXEL_WIDTH-1:0] window_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);

    state_t                 state_q, state_d;
    logic [COL_BITS-1:0]    col_q, col_d;
    logic                   row_flag_q, row_flag_d;
    logic                   win_valid_q, win_valid_d;
    logic                   accept;

    // lb1 holds row R-1, lb0 holds row R-2; never cleared, gating hides stale data
    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];

    // win[r][c]: r=0 oldest row, c=0 oldest column
    logic [PIXEL_WIDTH-1:0] win [3][3];

    // finish_i outranks the pixel in an armed state, so a finishing cycle drops its pixel
    assign accept = px_valid_i && (state_q != ST_IDLE) && !finish_i;
    assign busy_o = (state_q != ST_IDLE);
    assign window_valid_o = win_valid_q;

    // Next-state, column and row-flag logic
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_flag_d  = row_flag_q;
        win_valid_d = 1'b0;

        if (accept) begin
            col_d       = (col_q == COL_LAST) ? '0 : col_q + COL_BITS'(1);
            win_valid_d = (state_q == ST_STREAM) && (col_q >= COL_TWO);
            if (state_q == ST_PRIME && col_q == COL_LAST) begin
                if (row_flag_q) begin
                    state_d = ST_STREAM;
                end
                row_flag_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_PRIME;
                    col_d      = '0;
                    row_flag_d = 1'b0;
                end
            end
            ST_PRIME, ST_STREAM: begin
                if (finish_i) begin
                    state_d = ST_IDLE;
                end else if (start_i) begin
                    state_d    = ST_PRIME;
                    col_d      = '0;
                    row_flag_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_flag_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_flag_q  <= row_flag_d;
            win_valid_q <= win_valid_d;
        end
    end

    // Line buffers rotate the column: old R-1 becomes R-2, new pixel becomes R-1
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[col_q] <= lb1[col_q];
            lb1[col_q] <= px_gray_i;
        end
    end

    // Window shift register: new column enters at c=2, older columns move left
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[col_q];
            win[1][2] <= lb1[col_q];
            win[2][2] <= px_gray_i;
        end
    end

    // Flatten the window, element (r,c) at index 3*r+c
    always_comb begin
        window_o = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_o[PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// tb/tb_sobel_window_buffer.sv - directed self-checking bench for sobel_window_buffer
module tb_sobel_window_buffer;

    localparam int PW = 8;
    localparam int W  = 4;

    logic          clk_i = 1'b0;
    logic          nreset_i;
    logic          start_i;
    logic          finish_i;
    logic          px_valid_i;
    logic [PW-1:0] px_gray_i;
    logic          busy_o;
    logic          window_valid_o;
    logic [9*PW-1:0] window_o;

    int checks = 0;
    int errors = 0;

    logic [9*PW-1:0] win_q[$];
    logic [PW-1:0]   win_px_q[$];
    int              gap_pulses;
    logic [9*PW-1:0] exp_win [4];

    sobel_window_buffer #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W)) dut (
        .clk_i          (clk_i),
        .nreset_i       (nreset_i),
        .start_i        (start_i),
        .finish_i       (finish_i),
        .px_valid_i     (px_valid_i),
        .px_gray_i      (px_gray_i),
        .busy_o         (busy_o),
        .window_valid_o (window_valid_o),
        .window_o       (window_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock of stimulus; outputs sampled 1ns after the edge and windows logged
    task automatic px_cycle(input logic v, input logic [PW-1:0] d, input logic st, input logic fi);
        @(negedge clk_i);
        px_valid_i = v;
        px_gray_i  = d;
        start_i    = st;
        finish_i   = fi;
        @(posedge clk_i);
        #1;
        if (window_valid_o) begin
            win_q.push_back(window_o);
            win_px_q.push_back(d);
            if (!v) gap_pulses++;
        end
    endtask

    task automatic clear_log();
        win_q.delete();
        win_px_q.delete();
        gap_pulses = 0;
    endtask

    task automatic run_frame(input bit gaps);
        for (int p = 1; p <= 16; p++) begin
            px_cycle(1'b1, PW'(p), 1'b0, 1'b0);
            if (gaps) px_cycle(1'b0, 8'hEE, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        nreset_i = 1'b0; start_i = 1'b0; finish_i = 1'b0; px_valid_i = 1'b0; px_gray_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", window_valid_o); end
        checks++; if (window_o !== '0) begin errors++; $display("FAIL reset_window got %h want 0", window_o); end
        @(negedge clk_i);
        nreset_i = 1'b1;
    endtask

    task automatic test_stream();
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL stream_busy got %0b want 1", busy_o); end
        clear_log();
        run_frame(1'b0);
        checks++; if (win_q.size() !== 4) begin errors++; $display("FAIL stream_count got %0d want 4", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 4; i++) begin
            checks++; if (win_q[i] !== exp_win[i]) begin errors++; $display("FAIL stream_win%0d got %h want %h", i, win_q[i], exp_win[i]); end
        end
        if (win_px_q.size() > 0) begin
            checks++; if (win_px_q[0] !== 8'd11) begin errors++; $display("FAIL stream_first_px got %0d want 11", win_px_q[0]); end
        end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stream_finish_busy got %0b want 0", busy_o); end
    endtask

    task automatic test_gaps();
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        run_frame(1'b1);
        checks++; if (win_q.size() !== 4) begin errors++; $display("FAIL gaps_count got %0d want 4", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 4; i++) begin
            checks++; if (win_q[i] !== exp_win[i]) begin errors++; $display("FAIL gaps_win%0d got %h want %h", i, win_q[i], exp_win[i]); end
        end
        checks++; if (gap_pulses !== 0) begin errors++; $display("FAIL gaps_pulse got %0d want 0", gap_pulses); end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_idle_pixels();
        clear_log();
        for (int p = 0; p < 10; p++) px_cycle(1'b1, PW'(200 + p), 1'b0, 1'b0);
        checks++; if (win_q.size() !== 0) begin errors++; $display("FAIL idle_windows got %0d want 0", win_q.size()); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy_o); end
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        run_frame(1'b0);
        checks++; if (win_q.size() !== 4) begin errors++; $display("FAIL idle_count got %0d want 4", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 4; i++) begin
            checks++; if (win_q[i] !== exp_win[i]) begin errors++; $display("FAIL idle_win%0d got %h want %h", i, win_q[i], exp_win[i]); end
        end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_finish_mid();
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        for (int p = 1; p <= 10; p++) px_cycle(1'b1, PW'(p), 1'b0, 1'b0);
        px_cycle(1'b1, 8'd11, 1'b0, 1'b1);
        checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL fin_valid got %0b want 0", window_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fin_busy got %0b want 0", busy_o); end
        px_cycle(1'b1, 8'd12, 1'b0, 1'b0);
        checks++; if (win_q.size() !== 0) begin errors++; $display("FAIL fin_windows got %0d want 0", win_q.size()); end
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        run_frame(1'b0);
        checks++; if (win_q.size() !== 4) begin errors++; $display("FAIL fin_count got %0d want 4", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 4; i++) begin
            checks++; if (win_q[i] !== exp_win[i]) begin errors++; $display("FAIL fin_win%0d got %h want %h", i, win_q[i], exp_win[i]); end
        end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        for (int p = 1; p <= 12; p++) px_cycle(1'b1, PW'(p), 1'b0, 1'b0);
        checks++; if (window_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b want 1", window_valid_o); end
        checks++; if (window_o !== exp_win[1]) begin errors++; $display("FAIL rst_pre_win got %h want %h", window_o, exp_win[1]); end
        #2;
        nreset_i = 1'b0;
        #1;
        checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", window_valid_o); end
        checks++; if (window_o !== '0) begin errors++; $display("FAIL rst_mid_window got %h want 0", window_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", busy_o); end
        @(negedge clk_i);
        nreset_i = 1'b1;
        px_cycle(1'b1, 8'd99, 1'b0, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %0b want 0", busy_o); end
        px_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        run_frame(1'b0);
        checks++; if (win_q.size() !== 4) begin errors++; $display("FAIL rst_count got %0d want 4", win_q.size()); end
        for (int i = 0; i < win_q.size() && i < 4; i++) begin
            checks++; if (win_q[i] !== exp_win[i]) begin errors++; $display("FAIL rst_win%0d got %h want %h", i, win_q[i], exp_win[i]); end
        end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_start_finish();
        px_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sf_idle_busy got %0b want 1", busy_o); end
        px_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sf_prime_busy got %0b want 0", busy_o); end
        px_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sf_hold_busy got %0b want 0", busy_o); end
    endtask

    initial begin
        exp_win[0] = {8'd11, 8'd10, 8'd9,  8'd7,  8'd6,  8'd5, 8'd3, 8'd2, 8'd1};
        exp_win[1] = {8'd12, 8'd11, 8'd10, 8'd8,  8'd7,  8'd6, 8'd4, 8'd3, 8'd2};
        exp_win[2] = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        exp_win[3] = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6};
        gap_pulses = 0;
        test_reset();
        test_stream();
        test_gaps();
        test_idle_pixels();
        test_finish_mid();
        test_reset_mid();
        test_start_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Streaming line buffer and 3x3 window generator that sits directly downstream of the grayscale converter and feeds the Sobel gradient stage. It accepts one 8-bit gray pixel per valid cycle in raster order and keeps the two previous image rows in internal line buffers. Once three rows and three columns are available, it emits the complete 3x3 neighbourhood of each interior pixel. Border pixels produce no window.

## Interface
- PIXEL_WIDTH, 8, gray pixel width in bits; matches the converter output width
- IMG_WIDTH, 64, pixels per image row; must be >= 3
- COL_BITS, $clog2(IMG_WIDTH), column counter width (derived; do not override)
- clk_i  in  1  clock
- nreset_i  in  1  asynchronous, active-low reset
- start_i  in  1  frame start pulse; counters are cleared and the block is armed
- finish_i  in  1  frame end pulse; the block returns to idle
- px_valid_i  in  1  px_gray_i is valid this cycle
- px_gray_i  in  PIXEL_WIDTH  gray pixel, raster order
- busy_o  out  1  high while the state is not IDLE
- window_valid_o  out  1  window_o holds a new complete window
- window_o  out  9*PIXEL_WIDTH  3x3 window; element (r,c) is at [PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH]
  - r=0 is the oldest (top) row
  - c=0 is the oldest (left) column

## Operation
- States:
  - IDLE: pixels ignored.
  - PRIME: rows 0 and 1; pixels are stored, no windows.
  - STREAM: row >= 2; windows are emitted.
- State transitions:
  - IDLE -> PRIME on start_i. col and row_flag are cleared.
  - PRIME -> STREAM on the pixel accepted at col=IMG_WIDTH-1 while row_flag=1 (end of row 1).
  - PRIME or STREAM -> IDLE on finish_i.
  - In IDLE, start_i wins when start_i and finish_i arrive together.
  - In PRIME or STREAM, finish_i has priority over start_i and over px_valid_i. The pixel in that cycle is dropped.
- A pixel is accepted when px_valid_i=1, the state is PRIME or STREAM, and finish_i=0. Invalid cycles (gaps) do not change any state.
- Column counter col (COL_BITS wide):
  - Increments on every accepted pixel.
  - Wraps from IMG_WIDTH-1 to 0.
  - In PRIME, row_flag toggles 0->1 at the end of row 0.
- Line buffers: two arrays lb1 (row R-1) and lb0 (row R-2), each IMG_WIDTH x PIXEL_WIDTH. On an accepted pixel at column C, in the same edge:
  - the new column {lb0[C], lb1[C], px} is shifted into the window registers;
  - lb0[C] <= lb1[C];
  - lb1[C] <= px.
- Line buffers are not cleared on reset or start_i. Stale contents are never emitted because of the PRIME and column gating.
- Window registers form a 3x3 shift register. Column 2 receives the new column; columns 1 and 0 receive the older columns.
- window_valid_o is registered and is set to 1 on an accepted pixel when the state is STREAM and C >= 2; otherwise it is set to 0.
- The window centre is pixel (R-1, C-1). Columns left over from the previous row after a wrap are masked by the C >= 2 rule.
- No arithmetic is performed; data passes through unmodified at full width.

## Timing
- Reset values:
  - state=IDLE, col=0, row_flag=0.
  - busy_o=0, window_valid_o=0, window_o=0.
- Latency: window_valid_o and window_o update one cycle after the accepting edge.
  - window_valid_o stays high for exactly one cycle per accepted qualifying pixel.
  - window_o holds its value until the next accepted pixel.
- busy_o goes high in the cycle after start_i and low in the cycle after finish_i.
- Throughput: one pixel per cycle sustained, with no backpressure.
- Frame output: an IMG_WIDTH x H frame produces exactly (IMG_WIDTH-2)*(H-2) windows.
- Reset asserted mid-frame: all state clears asynchronously and window_valid_o drops immediately. start_i is required to resume.
- start_i in PRIME or STREAM (without finish_i) restarts the frame: it clears col and row_flag and enters PRIME.
- finish_i mid-row: the partial row is discarded. The next frame after start_i behaves exactly as from reset.

## Test plan
- IMG_WIDTH=4, start_i, then pixels 1..16 back-to-back ->
  - first window_valid_o in the cycle after pixel 11 is accepted;
  - window = {1,2,3,5,6,7,9,10,11};
  - exactly 4 valid windows; the last one is {6,7,8,10,11,12,14,15,16}.
- Same stream with px_valid_i toggling 1/0 -> identical window sequence, and window_valid_o pulses only after accepted pixels.
- Pixels driven in IDLE, then start_i and frame 1..16 -> pre-start pixels have no effect, and the windows are identical to the first test.
- finish_i together with pixel 11 -> no window, busy_o=0 next cycle. A restarted frame of 1..16 yields 4 correct windows.
- nreset_i pulsed after pixel 12 -> outputs are 0 immediately. After start_i and a full frame, the windows are correct.
- start_i and finish_i together in IDLE -> the block enters PRIME and busy_o=1 next cycle. Repeated in PRIME -> the block returns to IDLE.
